// File: rtl/reg_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// reg_share_arbiter_if
// Bundles the requester-side bus of the shared-register arbiter.
//   req     : per-requester level write request
//   wdata   : flattened requester data, requester i at [i*WIDTH +: WIDTH]
//   flush   : synchronous abort/clear, active-high
//   grant   : one-hot grant pulse
//   q       : shared register contents
//   q_valid : q holds data written since the last reset/flush
//   owner   : index of the requester that last wrote q
//   busy    : arbiter is in a grant or hold window
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface reg_share_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] wdata;
    logic                     flush;
    logic [NUM_REQ-1:0]       grant;
    logic [WIDTH-1:0]         q;
    logic                     q_valid;
    logic [OW-1:0]            owner;
    logic                     busy;

    modport master (
        output req, wdata, flush,
        input  grant, q, q_valid, owner, busy
    );

    modport slave (
        input  req, wdata, flush,
        output grant, q, q_valid, owner, busy
    );
endinterface

// File: rtl/reg_share_arbiter.sv
// ---------------------------------------------------------------------------
// reg_share_arbiter
// Round-robin controller sharing one WIDTH-bit register among NUM_REQ
// requesters. A winning request loads its data into q in the GRANT cycle,
// then the arbiter waits HOLD_CYCLES cycles before arbitrating again.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : reg_share_arbiter_if.slave (req/wdata/flush in,
//           grant/q/q_valid/owner/busy out, all outputs registered)
// ---------------------------------------------------------------------------
module reg_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int WIDTH       = 8,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    reg_share_arbiter_if.slave    bus
);
    localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0]    HOLD_LOAD = 4'(HOLD_CYCLES);
    localparam logic [OW-1:0] LAST_IDX  = OW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                state_r;
    logic [NUM_REQ-1:0]    grant_r;
    logic [WIDTH-1:0]      q_r;
    logic                  q_valid_r;
    logic [OW-1:0]         owner_r;
    logic                  busy_r;
    logic [OW-1:0]         rr_ptr_r;
    logic [3:0]            hold_cnt_r;

    logic                  found_s;
    logic [OW-1:0]         win_s;
    logic [OW-1:0]         rr_next_s;
    logic [NUM_REQ-1:0]    onehot_s;
    logic [WIDTH-1:0]      sel_data_s;
    logic [WIDTH-1:0]      wdata_arr_s [NUM_REQ];

    // Index reached by stepping k places up from ptr, wrapping modulo NUM_REQ.
    // One extra bit holds the sum before the wrap so nothing overflows.
    function automatic logic [OW-1:0] rr_index(input logic [OW-1:0] ptr, input int k);
        logic [OW:0] sum;
        sum = {1'b0, ptr} + (OW+1)'(k);
        if (sum >= (OW+1)'(NUM_REQ)) begin
            sum = sum - (OW+1)'(NUM_REQ);
        end else begin
            sum = sum;
        end
        return sum[OW-1:0];
    endfunction

    // Unpack the flattened requester data into one word per requester.
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign wdata_arr_s[i] = bus.wdata[i*WIDTH +: WIDTH];
    end

    // Round-robin search: first active request at or above the pointer.
    always_comb begin
        found_s    = 1'b0;
        win_s      = {OW{1'b0}};
        sel_data_s = {WIDTH{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_s && bus.req[rr_index(rr_ptr_r, k)]) begin
                found_s    = 1'b1;
                win_s      = rr_index(rr_ptr_r, k);
                sel_data_s = wdata_arr_s[rr_index(rr_ptr_r, k)];
            end else begin
                found_s = found_s;
            end
        end
        if (win_s == LAST_IDX) begin
            rr_next_s = {OW{1'b0}};
        end else begin
            rr_next_s = win_s + OW'(1);
        end
        onehot_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_s;
    end

    // Arbitration FSM and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            grant_r    <= {NUM_REQ{1'b0}};
            q_r        <= {WIDTH{1'b0}};
            q_valid_r  <= 1'b0;
            owner_r    <= {OW{1'b0}};
            busy_r     <= 1'b0;
            rr_ptr_r   <= {OW{1'b0}};
            hold_cnt_r <= 4'd0;
        end else if (bus.flush) begin
            // Abort wins over any pending request; owner and pointer persist.
            state_r    <= ST_IDLE;
            grant_r    <= {NUM_REQ{1'b0}};
            q_r        <= {WIDTH{1'b0}};
            q_valid_r  <= 1'b0;
            busy_r     <= 1'b0;
            hold_cnt_r <= 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (found_s) begin
                        grant_r   <= onehot_s;
                        q_r       <= sel_data_s;
                        q_valid_r <= 1'b1;
                        owner_r   <= win_s;
                        rr_ptr_r  <= rr_next_s;
                        busy_r    <= 1'b1;
                        state_r   <= ST_GRANT;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    grant_r <= {NUM_REQ{1'b0}};
                    if (HOLD_LOAD == 4'd0) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        hold_cnt_r <= HOLD_LOAD;
                        state_r    <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Leave on the 1->0 step; a zero count is treated the same
                    // so a corrupted counter cannot stall the arbiter.
                    if (hold_cnt_r <= 4'd1) begin
                        hold_cnt_r <= 4'd0;
                        busy_r     <= 1'b0;
                        state_r    <= ST_IDLE;
                    end else begin
                        hold_cnt_r <= hold_cnt_r - 4'd1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    grant_r    <= {NUM_REQ{1'b0}};
                    busy_r     <= 1'b0;
                    hold_cnt_r <= 4'd0;
                end
            endcase
        end
    end

    assign bus.grant   = grant_r;
    assign bus.q       = q_r;
    assign bus.q_valid = q_valid_r;
    assign bus.owner   = owner_r;
    assign bus.busy    = busy_r;

endmodule

// File: doc/reg_share_arbiter.md
Name: reg_share_arbiter

Overview:
Round-robin arbiter/controller that shares one WIDTH-bit D-register between NUM_REQ requesters. It grants write access to one requester at a time and loads that requester's data into the shared register. It then enforces a hold window before the next arbitration. It sits between the requesting blocks and the shared storage flop bank and sequences every write into it.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, width of the shared register and each requester's data
HOLD_CYCLES, 2, idle cycles after each grant before re-arbitration (0..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
req  input  NUM_REQ  per-requester write request, level, held until granted
wdata  input  NUM_REQ*WIDTH  flattened data; requester i occupies bits [i*WIDTH +: WIDTH]
flush  input  1  synchronous abort/clear, active-high
grant  output  NUM_REQ  one-hot grant pulse, registered
q  output  WIDTH  shared register contents
q_valid  output  1  q holds data written by a grant since the last reset/flush
owner  output  clog2(NUM_REQ)  index of the requester that last wrote q
busy  output  1  high in GRANT and HOLD states

Behaviour:
- Reset (reset=0, asynchronous, immediate): state=IDLE; grant=0, q=0, q_valid=0, owner=0, busy=0, rr pointer=0, hold counter=0. Applies mid-GRANT/HOLD too; no partial write survives.
- All outputs are registered (driven from flops); no combinational path from req/wdata to outputs.
- States: IDLE, GRANT, HOLD.
- IDLE: req sampled at each rising edge. If flush=0 and |req:
  - winner = first set bit of req searching from the rr pointer upward, wrapping mod NUM_REQ.
  - Same edge: grant<=onehot(winner), q<=wdata[winner], owner<=winner, q_valid<=1, rr pointer<=(winner+1) mod NUM_REQ, state<=GRANT.
  - If no req: stay in IDLE, outputs unchanged.
- GRANT: lasts exactly 1 cycle; grant is high only in this cycle.
  - Next edge: grant<=0.
  - If HOLD_CYCLES=0, state<=IDLE; otherwise state<=HOLD with counter<=HOLD_CYCLES.
- HOLD: counter decrements each edge; state<=IDLE on the edge where counter goes 1->0. HOLD therefore lasts exactly HOLD_CYCLES cycles. req is ignored during GRANT and HOLD.
- Latency: req high in an IDLE cycle -> grant and q updated in the next cycle.
  - With continuous requests, grant spacing is HOLD_CYCLES+2 cycles (4 at defaults).
- Requester protocol: keep req and wdata stable until grant is seen; deassert req in the cycle after grant.
  - A req still high on return to IDLE is treated as a new request.
  - A req dropped before sampling is never granted.
- flush=1 at any edge, any state: state<=IDLE, grant<=0, q<=0, q_valid<=0, counter<=0. owner and rr pointer are unchanged.
  - flush has priority over a simultaneous IDLE request: no grant that cycle.
- Fairness: a requester held high is granted within NUM_REQ arbitrations.
- Wrap: after a grant to NUM_REQ-1, the search starts at 0.
- owner width: max(1, clog2(NUM_REQ)).

Test Plan:
- Reset: hold reset=0 with req=4'b1111, toggle clk -> grant=0, q=8'h00, q_valid=0, busy=0; release reset -> first grant one cycle after the next edge.
- Single request: req=4'b0100, wdata[2]=8'hA5 -> next cycle grant=4'b0100, q=8'hA5, owner=2, q_valid=1, busy=1; busy stays high 2 more cycles (HOLD), then drops.
- Round-robin: req=4'b1111 continuous, distinct data 8'h10/8'h11/8'h12/8'h13 -> grants 0001,0010,0100,1000,0001 spaced 4 cycles apart; q tracks each grantee's data.
- Wrap/skip: grant to 3, then req=4'b0101 -> next grant=4'b0001, then 4'b0100.
- Flush collision: in IDLE assert flush=1 and req=4'b0010 on the same edge -> grant=0, q=0, q_valid=0; flush during HOLD -> IDLE on the next edge, and a pending req is granted one cycle later.
- Async reset mid-HOLD: drop reset between clock edges -> outputs clear immediately without waiting for clk; after release, req=4'b1000 is granted (pointer back at 0, search order 0..3).
